// File: rtl/map_dia_pipe.sv
// Multi-channel shift-and-add mapper: all channels are consumed together, their
// shifted sum is registered, then queued in a 2-deep FIFO toward the output.
module map_dia_pipe #(
    parameter int               NCH  = 3,
    parameter int               W    = 16,
    parameter int               OUTW = 16,
    parameter logic [NCH*5-1:0] SH   = {5'd7, 5'd5, 5'd2},
    parameter bit               SAT  = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    In_SEND,
    input  logic [NCH*W-1:0]  In_DATA,
    input  logic [NCH*16-1:0] In_COUNT,
    output logic [NCH-1:0]    In_ACK,
    input  logic              Out_RDY,
    input  logic              Out_ACK,
    output logic              Out_SEND,
    output logic [OUTW-1:0]   Out_DATA,
    output logic [15:0]       Out_COUNT,
    input  logic              CLR,
    output logic [31:0]       FIRED,
    output logic              SAT_FLAG
);

    function automatic int max_sh();
        int m;
        m = 0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(SH[5*i +: 5]) > m) m = int'(SH[5*i +: 5]);
        end
        return m;
    endfunction

    localparam int SW = W + max_sh() + $clog2(NCH);

    logic [SW-1:0]   sum;
    logic [SW-1:0]   s1_q;
    logic            s1_valid_q;
    logic [OUTW-1:0] mem_q [2];
    logic            wr_q, rd_q;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     fired_q, fired_d;
    logic            sat_flag_q, sat_flag_d;
    logic [1:0]      inflight;
    logic            push, pop, fire, ovf;
    logic [OUTW-1:0] res;
    logic            unused_ok;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = sum + (SW'(In_DATA[W*i +: W]) << SH[5*i +: 5]);
        end
    end

    // Overflow means any sum bit at or above OUTW is set.
    if (SW > OUTW) begin : g_wide
        assign ovf = |s1_q[SW-1:OUTW];
        assign res = (SAT && ovf) ? {OUTW{1'b1}} : s1_q[OUTW-1:0];
    end else begin : g_narrow
        assign ovf = 1'b0;
        assign res = OUTW'(s1_q);
    end

    assign push     = s1_valid_q;
    assign pop      = !RESET && (cnt_q != 2'd0) && Out_RDY;
    assign inflight = {1'b0, s1_valid_q} + cnt_q;
    // Capping inflight at 2 keeps the unconditional S1->FIFO push from overflowing.
    assign fire     = !RESET && (&In_SEND) && ((inflight < 2'd2) || pop);

    assign In_ACK    = {NCH{fire}};
    assign Out_SEND  = pop;
    assign Out_DATA  = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
    assign Out_COUNT = 16'h1;
    assign FIRED     = fired_q;
    assign SAT_FLAG  = sat_flag_q;
    assign unused_ok = ^{In_COUNT, Out_ACK};

    always_comb begin
        cnt_d      = cnt_q;
        fired_d    = fired_q;
        sat_flag_d = sat_flag_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
        if (CLR) begin
            fired_d    = '0;
            sat_flag_d = 1'b0;
        end else begin
            if (fire)        fired_d    = fired_q + 32'd1;
            if (push && ovf) sat_flag_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= 2'd0;
            fired_q    <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            s1_valid_q <= fire;
            if (fire) s1_q <= sum;
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            cnt_q      <= cnt_d;
            fired_q    <= fired_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= res;
    end

endmodule

// File: tb/tb_map_dia_pipe.sv
// Scoreboard bench for map_dia_pipe: a wrap-mode and a saturate-mode instance
// share stimulus; a negedge monitor pops expected tokens per instance.
module tb_map_dia_pipe;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  In_SEND = '0;
    logic [47:0] In_DATA = '0;
    logic [47:0] In_COUNT = '0;
    logic        Out_RDY = 1'b0;
    logic        Out_ACK = 1'b0;
    logic        CLR = 1'b0;

    logic [2:0]  ack0, ack1;
    logic        send0, send1;
    logic [15:0] data0, data1, cnt0, cnt1;
    logic [31:0] fired0, fired1;
    logic        satf0, satf1;

    int tests = 0;
    int fails = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 CLK = ~CLK;

    map_dia_pipe #(.SAT(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .In_SEND(In_SEND), .In_DATA(In_DATA),
        .In_COUNT(In_COUNT), .In_ACK(ack0), .Out_RDY(Out_RDY), .Out_ACK(Out_ACK),
        .Out_SEND(send0), .Out_DATA(data0), .Out_COUNT(cnt0), .CLR(CLR),
        .FIRED(fired0), .SAT_FLAG(satf0));

    map_dia_pipe #(.SAT(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .In_SEND(In_SEND), .In_DATA(In_DATA),
        .In_COUNT(In_COUNT), .In_ACK(ack1), .Out_RDY(Out_RDY), .Out_ACK(Out_ACK),
        .Out_SEND(send1), .Out_DATA(data1), .Out_COUNT(cnt1), .CLR(CLR),
        .FIRED(fired1), .SAT_FLAG(satf1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sum of ch0<<2, ch1<<5, ch2<<7, then wrap or saturate to 16 bits.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input bit sat);
        logic [24:0] s;
        s = (25'(a) << 2) + (25'(b) << 5) + (25'(c) << 7);
        if (s > 25'h00FFFF && sat) return 16'hFFFF;
        return s[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_tok(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] e0, input logic [15:0] e1);
        bit got;
        got = 1'b0;
        In_DATA = {c, b, a};
        In_SEND = 3'b111;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            if (ack0 == 3'b111) begin
                q0.push_back(e0);
                q1.push_back(e1);
                got = 1'b1;
            end
            tick();
        end
        In_SEND = 3'b000;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no In_ACK expected 7");
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (send0) begin
                if (q0.size() == 0) check("unexpected_out_wrap", {16'h0, data0}, 32'hDEAD_BEEF);
                else                check("out_wrap", {16'h0, data0}, {16'h0, q0.pop_front()});
            end
            if (send1) begin
                if (q1.size() == 0) check("unexpected_out_sat", {16'h0, data1}, 32'hDEAD_BEEF);
                else                check("out_sat", {16'h0, data1}, {16'h0, q1.pop_front()});
            end
            if (ack0 != 3'b000) check("ack_all_or_none", {29'h0, In_SEND}, 32'h7);
        end
    end

    initial begin
        int n;
        logic [15:0] a, b, c;

        // Reset state, with all channels offering a token.
        In_DATA = {16'd3, 16'd2, 16'd1};
        In_SEND = 3'b111;
        Out_RDY = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        check("rst_in_ack", {29'h0, ack0}, 32'h0);
        check("rst_out_send", {31'h0, send0}, 32'h0);
        check("rst_out_data", {16'h0, data0}, 32'h0);
        check("rst_out_count", {16'h0, cnt0}, 32'h1);
        check("rst_fired", fired0, 32'h0);
        check("rst_sat_flag", {31'h0, satf0}, 32'h0);

        // First fire right after reset; 2-cycle latency.
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("first_fire_ack", {29'h0, ack0}, 32'h7);
        q0.push_back(16'h01C4);
        q1.push_back(16'h01C4);
        tick();
        In_SEND = 3'b000;
        @(negedge CLK);
        check("lat_t1_send", {31'h0, send0}, 32'h0);
        check("fired_one", fired0, 32'h1);
        @(negedge CLK);
        check("lat_t2_send", {31'h0, send0}, 32'h1);
        check("lat_t2_data", {16'h0, data0}, 32'h01C4);
        tick();
        tick();

        // CLR, then partial SEND must never consume.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        @(negedge CLK);
        check("clr_fired", fired0, 32'h0);
        In_DATA = {16'd9, 16'd8, 16'd7};
        In_SEND = 3'b011;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge CLK);
            check("partial_ack", {29'h0, ack0}, 32'h0);
            check("partial_send", {31'h0, send0}, 32'h0);
        end
        check("partial_fired", fired0, 32'h0);
        tick();
        In_SEND = 3'b000;

        // Overflow: 0x200<<7 = 0x10000.
        send_tok(16'h0, 16'h0, 16'h0200, 16'h0000, 16'hFFFF);
        tick();
        tick();
        @(negedge CLK);
        check("ovf_flag_wrap", {31'h0, satf0}, 32'h1);
        check("ovf_flag_sat", {31'h0, satf1}, 32'h1);
        tick();
        send_tok(16'hFFFF, 16'h0001, 16'h01FF, model(16'hFFFF, 16'h0001, 16'h01FF, 1'b0),
                 model(16'hFFFF, 16'h0001, 16'h01FF, 1'b1));
        tick();
        tick();
        tick();

        // Backpressure: exactly two fires, then 1/cycle once Out_RDY returns.
        Out_RDY = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            a = 16'h0100 + 16'(k);
            b = 16'h0010 * 16'(k);
            c = 16'h0040 + 16'(k);
            In_DATA = {c, b, a};
            In_SEND = 3'b111;
            @(negedge CLK);
            if (ack0 == 3'b111) begin
                q0.push_back(model(a, b, c, 1'b0));
                q1.push_back(model(a, b, c, 1'b1));
                n++;
            end
            tick();
        end
        check("stall_fires", n, 32'd2);
        Out_RDY = 1'b1;
        n = 0;
        for (int k = 6; k < 14; k++) begin
            a = 16'h0100 + 16'(k);
            b = 16'h0800 * 16'(k);
            c = 16'h0040 + 16'(k);
            In_DATA = {c, b, a};
            @(negedge CLK);
            if (ack0 == 3'b111) begin
                q0.push_back(model(a, b, c, 1'b0));
                q1.push_back(model(a, b, c, 1'b1));
                n++;
            end
            tick();
        end
        check("resume_fires", n, 32'd8);
        In_SEND = 3'b000;
        for (int k = 0; k < 5; k++) tick();

        // Reset with two tokens in flight discards them.
        Out_RDY = 1'b0;
        send_tok(16'h0, 16'h0, 16'h0200, 16'h0000, 16'hFFFF);
        send_tok(16'd1, 16'd2, 16'd3, 16'h01C4, 16'h01C4);
        tick();
        @(negedge CLK);
        check("pre_rst_sat_flag", {31'h0, satf0}, 32'h1);
        tick();
        RESET = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge CLK);
        check("midrst_fired", fired0, 32'h0);
        check("midrst_sat_flag", {31'h0, satf0}, 32'h0);
        check("midrst_out_send", {31'h0, send0}, 32'h0);
        tick();
        RESET = 1'b0;
        Out_RDY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("post_rst_send", {31'h0, send0 | send1}, 32'h0);
            tick();
        end

        // CLR beats a same-cycle fire and a same-cycle overflow.
        send_tok(16'd4, 16'd5, 16'd6, model(16'd4, 16'd5, 16'd6, 1'b0), model(16'd4, 16'd5, 16'd6, 1'b1));
        send_tok(16'd7, 16'd0, 16'd1, model(16'd7, 16'd0, 16'd1, 1'b0), model(16'd7, 16'd0, 16'd1, 1'b1));
        @(negedge CLK);
        check("fired_two", fired0, 32'h2);
        tick();
        In_DATA = {16'd1, 16'd1, 16'd1};
        In_SEND = 3'b111;
        CLR = 1'b1;
        @(negedge CLK);
        check("clr_fire_ack", {29'h0, ack0}, 32'h7);
        q0.push_back(16'h00A4);
        q1.push_back(16'h00A4);
        tick();
        CLR = 1'b0;
        In_SEND = 3'b000;
        @(negedge CLK);
        check("clr_fire_fired", fired0, 32'h0);
        tick();
        send_tok(16'h0, 16'h0, 16'h0300, 16'h8000, 16'hFFFF);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        @(negedge CLK);
        check("clr_ovf_sat_flag", {31'h0, satf0}, 32'h0);
        check("clr_ovf_fired", fired0, 32'h0);

        for (int k = 0; k < 6; k++) tick();
        check("drain_wrap", q0.size(), 32'd0);
        check("drain_sat", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
